bht_rmw_ctrl: RTL and testbench

Branch-history-table controller for the branch-predictor benchmark. It owns a 1r1w counter table, built from one `vc_ResetRegfile_1r1w` instance, and sweeps it to a known value after reset. It then shares the table's single read port between predict lookups and buffered read-modify-write updates of saturating counters. It sits between the fetch-side predictor front end and the branch-resolution path.

---
 rtl/bht_rmw_ctrl_pkg.sv | 30 +++
 rtl/bht_rmw_ctrl_regfile.sv | 31 +++
 rtl/bht_rmw_ctrl.sv | 148 ++++++++++++++
 tb/tb_bht_rmw_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/bht_rmw_ctrl_pkg.sv
// Shared types and the saturating-counter helper for the branch-history-table controller.
package bht_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bht_state_e;

    typedef enum logic {
        ARB_PRED = 1'b0,
        ARB_UPD  = 1'b1
    } bht_arb_e;

    // Widest counter the helper supports; callers cast the result to their width.
    localparam int unsigned CTR_MAX_NBITS = 8;

    function automatic logic [CTR_MAX_NBITS-1:0] sat_update(
        input logic [CTR_MAX_NBITS-1:0] ctr,
        input logic                     taken,
        input int unsigned              nbits
    );
        logic [CTR_MAX_NBITS-1:0] max_v;
        max_v = CTR_MAX_NBITS'((64'd1 << nbits) - 64'd1);
        if (taken) begin
            return (ctr >= max_v) ? max_v : ctr + 1'b1;
        end
        return (ctr == '0) ? '0 : ctr - 1'b1;
    endfunction

endpackage

// File: rtl/bht_rmw_ctrl_regfile.sv
// 1-read/1-write register file with synchronous reset; combinational read, write at clock edge.
module vc_ResetRegfile_1r1w #(
    parameter int                      p_data_nbits  = 1,
    parameter int                      p_num_entries = 2,
    parameter logic [p_data_nbits-1:0] p_reset_value = '0,
    localparam int                     c_addr_nbits  = $clog2(p_num_entries)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [c_addr_nbits-1:0] read_addr,
    output logic [p_data_nbits-1:0] read_data,
    input  logic                    write_en,
    input  logic [c_addr_nbits-1:0] write_addr,
    input  logic [p_data_nbits-1:0] write_data
);

    logic [p_data_nbits-1:0] rfile_q [p_num_entries];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < p_num_entries; i++) begin
                rfile_q[i] <= p_reset_value;
            end
        end else if (write_en) begin
            rfile_q[write_addr] <= write_data;
        end
    end

    assign read_data = rfile_q[read_addr];

endmodule

// File: rtl/bht_rmw_ctrl.sv
// Branch-history-table controller: post-reset sweep, then predict lookups and buffered counter updates
// share one read port. Define BHT_CTRL_RR_ARB_EN for round-robin arbitration on contended cycles.
module bht_rmw_ctrl
    import bht_pkg::*;
#(
    parameter int  p_num_entries = 64,
    parameter int  p_ctr_nbits   = 2,
    localparam int c_addr_nbits  = $clog2(p_num_entries)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pred_val,
    output logic                    pred_rdy,
    input  logic [c_addr_nbits-1:0] pred_idx,
    output logic                    pred_taken,
    input  logic                    upd_val,
    output logic                    upd_rdy,
    input  logic [c_addr_nbits-1:0] upd_idx,
    input  logic                    upd_taken,
    output logic                    init_done
);

    localparam logic [p_ctr_nbits-1:0] c_init_val = p_ctr_nbits'((1 << (p_ctr_nbits - 1)) - 1);
    localparam logic [c_addr_nbits-1:0] c_last_idx = c_addr_nbits'(p_num_entries - 1);

    bht_state_e              state_q, state_d;
    logic [c_addr_nbits-1:0] sweep_q, sweep_d;
    logic                    pend_val_q, pend_val_d;
    logic [c_addr_nbits-1:0] pend_idx_q, pend_idx_d;
    logic                    pend_taken_q, pend_taken_d;
`ifdef BHT_CTRL_RR_ARB_EN
    bht_arb_e                arb_ptr_q, arb_ptr_d;
`endif

    logic                    run;
    logic                    contended;
    logic                    pred_win;
    logic                    upd_grant;
    logic [c_addr_nbits-1:0] rf_raddr;
    logic [p_ctr_nbits-1:0]  rf_rdata;
    logic                    rf_wen;
    logic [c_addr_nbits-1:0] rf_waddr;
    logic [p_ctr_nbits-1:0]  rf_wdata;

    vc_ResetRegfile_1r1w #(
        .p_data_nbits  (p_ctr_nbits),
        .p_num_entries (p_num_entries)
    ) u_table (
        .clk        (clk),
        .reset      (reset),
        .read_addr  (rf_raddr),
        .read_data  (rf_rdata),
        .write_en   (rf_wen),
        .write_addr (rf_waddr),
        .write_data (rf_wdata)
    );

    always_comb begin
        state_d      = state_q;
        sweep_d      = sweep_q;
        pend_val_d   = pend_val_q;
        pend_idx_d   = pend_idx_q;
        pend_taken_d = pend_taken_q;
`ifdef BHT_CTRL_RR_ARB_EN
        arb_ptr_d    = arb_ptr_q;
`endif
        rf_raddr     = pred_idx;
        rf_wen       = 1'b0;
        rf_waddr     = pend_idx_q;
        rf_wdata     = c_init_val;

        // Requests seen while reset is high are never accepted, whatever state_q holds.
        run       = (state_q == ST_RUN) && !reset;
        contended = run && pred_val && pend_val_q;

        if (!run) begin
            pred_win = 1'b0;
        end else if (contended) begin
`ifdef BHT_CTRL_RR_ARB_EN
            pred_win = (arb_ptr_q == ARB_PRED);
`else
            pred_win = 1'b1;
`endif
        end else begin
            pred_win = pred_val;
        end

        upd_grant  = run && pend_val_q && !pred_win;
        pred_rdy   = pred_win;
        upd_rdy    = run && (!pend_val_q || upd_grant);
        init_done  = (state_q == ST_RUN) && !reset;

        if (state_q == ST_INIT) begin
            rf_wen   = 1'b1;
            rf_waddr = sweep_q;
            rf_wdata = c_init_val;
            sweep_d  = sweep_q + c_addr_nbits'(1);
            if (sweep_q == c_last_idx) begin
                state_d = ST_RUN;
            end
        end else if (upd_grant) begin
            rf_raddr = pend_idx_q;
            rf_wen   = 1'b1;
            rf_waddr = pend_idx_q;
            rf_wdata = p_ctr_nbits'(sat_update(CTR_MAX_NBITS'(rf_rdata), pend_taken_q, p_ctr_nbits));
        end

        // A refill in the retire cycle takes priority over clearing the buffer.
        if (upd_val && upd_rdy) begin
            pend_val_d   = 1'b1;
            pend_idx_d   = upd_idx;
            pend_taken_d = upd_taken;
        end else if (upd_grant) begin
            pend_val_d   = 1'b0;
        end

`ifdef BHT_CTRL_RR_ARB_EN
        if (contended) begin
            arb_ptr_d = pred_win ? ARB_UPD : ARB_PRED;
        end
`endif
    end

    assign pred_taken = rf_rdata[p_ctr_nbits-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_INIT;
            sweep_q      <= '0;
            pend_val_q   <= 1'b0;
            pend_idx_q   <= '0;
            pend_taken_q <= 1'b0;
`ifdef BHT_CTRL_RR_ARB_EN
            arb_ptr_q    <= ARB_PRED;
`endif
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            pend_val_q   <= pend_val_d;
            pend_idx_q   <= pend_idx_d;
            pend_taken_q <= pend_taken_d;
`ifdef BHT_CTRL_RR_ARB_EN
            arb_ptr_q    <= arb_ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_bht_rmw_ctrl.sv
// Directed bench for bht_rmw_ctrl with 16 two-bit counters; predict results checked through a scoreboard queue.
module tb_bht_rmw_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pred_val = 1'b0;
    logic       pred_rdy;
    logic [3:0] pred_idx = '0;
    logic       pred_taken;
    logic       upd_val = 1'b0;
    logic       upd_rdy;
    logic [3:0] upd_idx = '0;
    logic       upd_taken = 1'b0;
    logic       init_done;

    int   total = 0;
    int   bad = 0;
    logic sb_q[$];
    int   mdl[16];

    bht_rmw_ctrl #(
        .p_num_entries (16),
        .p_ctr_nbits   (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pred_val   (pred_val),
        .pred_rdy   (pred_rdy),
        .pred_idx   (pred_idx),
        .pred_taken (pred_taken),
        .upd_val    (upd_val),
        .upd_rdy    (upd_rdy),
        .upd_idx    (upd_idx),
        .upd_taken  (upd_taken),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input bit t);
        if (t) return (v >= 3) ? 3 : v + 1;
        return (v <= 0) ? 0 : v - 1;
    endfunction

    // One clock cycle of stimulus; outputs sampled at the falling edge.
    task automatic step(input bit pv, input int pidx, input bit uv, input int uidx, input bit ut,
                        input bit exp_prdy, input bit exp_ptaken, input bit exp_urdy);
        pred_val  = pv;
        pred_idx  = 4'(pidx);
        upd_val   = uv;
        upd_idx   = 4'(uidx);
        upd_taken = ut;
        if (pv) sb_q.push_back(exp_ptaken);
        @(negedge clk);
        check("pred_rdy", pred_rdy, exp_prdy);
        check("upd_rdy", upd_rdy, exp_urdy);
        if (pv) begin
            if (pred_rdy === 1'b1) check("pred_taken", pred_taken, sb_q.pop_front());
            else void'(sb_q.pop_front());
        end
        @(posedge clk);
        #1;
        pred_val = 1'b0;
        upd_val  = 1'b0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic upd(input int idx, input bit t);
        step(0, 0, 1, idx, t, 0, 0, 1);
        mdl[idx] = sat(mdl[idx], t);
    endtask

    task automatic pred(input int idx);
        step(1, idx, 0, 0, 0, 1, (mdl[idx] >= 2), 1);
    endtask

    // One reset cycle with requests presented, then the 16-cycle sweep.
    task automatic reset_and_sweep();
        reset    = 1'b1;
        pred_val = 1'b1;
        upd_val  = 1'b1;
        upd_idx  = 4'd3;
        @(negedge clk);
        check("rst_pred_rdy", pred_rdy, 0);
        check("rst_upd_rdy", upd_rdy, 0);
        check("rst_init_done", init_done, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("sweep_init_done", init_done, 0);
            check("sweep_pred_rdy", pred_rdy, 0);
            check("sweep_upd_rdy", upd_rdy, 0);
            @(posedge clk);
            #1;
        end
        pred_val = 1'b0;
        upd_val  = 1'b0;
        @(negedge clk);
        check("sweep_done", init_done, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) mdl[i] = 1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        reset_and_sweep();
        for (int i = 0; i < 16; i++) pred(i);

        // saturating increment on idx 5
        upd(5, 1); upd(5, 1); upd(5, 1); idle();
        pred(5);
        upd(5, 1); idle(); pred(5);
        upd(5, 0); idle(); pred(5);
        upd(5, 0); idle(); pred(5);

        // saturating decrement on idx 9
        upd(9, 0); upd(9, 0); upd(9, 0); idle();
        pred(9);
        upd(9, 1); idle(); pred(9);
        upd(9, 1); idle(); pred(9);

        // contention on idx 2 (counter 1, taken update pending)
        step(0, 0, 1, 2, 1, 0, 0, 1);
`ifdef BHT_CTRL_RR_ARB_EN
        step(1, 2, 0, 0, 0, 1, 0, 0);
        step(1, 2, 0, 0, 0, 0, 0, 1);
        mdl[2] = 2;
        step(1, 2, 0, 0, 0, 1, 1, 1);
`else
        for (int i = 0; i < 4; i++) step(1, 2, 0, 0, 0, 1, 0, 0);
        idle();
        mdl[2] = 2;
        pred(2);
`endif

        // staleness: update and predict of idx 4 in the same cycle
        step(1, 4, 1, 4, 1, 1, 0, 1);
        mdl[4] = sat(mdl[4], 1);
        idle();
        pred(4);

        // back-to-back updates
        upd(0, 1); upd(1, 0); upd(2, 1); idle();
        pred(0); pred(1); pred(2);

        // mid-operation reset with an update pending
        upd(7, 1);
        reset_and_sweep();
        idle(); idle();
        for (int i = 0; i < 16; i++) pred(i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
